// File: rtl/pll_divn_ramp_ctrl.sv
// pll_divn_ramp_ctrl: sequencer for the PLL feedback divider.
// Takes a new divn target over a valid/ready handshake. It steps the divn output
// toward that target, holding after each step, and pulses brake ahead of large jumps.
// It then waits for the synchronised PLL lock and reports done or a sticky timeout.
// Optional feature macro: PLL_RAMP_ABORT_EN adds the abort/aborted ports.
//
// Handshake: a request is accepted on a pclk edge where req_valid && req_ready.
// req_ready is high only in IDLE. Requests offered while busy are not captured,
// so the requester keeps req_valid high until it sees req_ready.
module pll_divn_ramp_ctrl #(
    parameter int DIVN_W       = 16,
    parameter int DIVN_INIT    = 100,
    parameter int DIVN_MIN     = 4,
    parameter int STEP         = 1,
    parameter int HOLD_CYCLES  = 256,
    parameter int BRAKE_THRESH = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              pclk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DIVN_W-1:0] req_divn,
    input  logic              locked,
    input  logic              clr_err,
`ifdef PLL_RAMP_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic [DIVN_W-1:0] divn,
    output logic              brake,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [2:0]        dbg_state
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LOCK_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [DIVN_W-1:0] DIVN_INIT_V = DIVN_W'(DIVN_INIT);
    localparam logic [DIVN_W-1:0] DIVN_MIN_V  = DIVN_W'(DIVN_MIN);
    localparam logic [DIVN_W-1:0] STEP_V      = DIVN_W'(STEP);
    localparam logic [DIVN_W-1:0] BRAKE_V     = DIVN_W'(BRAKE_THRESH);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_BRAKE     = 3'd1,
        S_STEP      = 3'd2,
        S_HOLD      = 3'd3,
        S_WAIT_LOCK = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [DIVN_W-1:0]   divn_q, divn_d;
    logic [DIVN_W-1:0]   target_q, target_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                brake_q, brake_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                lock_meta_q, lock_meta_d;
    logic                lock_sync_q, lock_sync_d;
`ifdef PLL_RAMP_ABORT_EN
    logic                aborted_q, aborted_d;
`endif

    logic [DIVN_W-1:0]   req_tgt;
    logic [DIVN_W-1:0]   req_diff;
    logic [DIVN_W-1:0]   cur_diff;
    logic [DIVN_W-1:0]   step_amt;

    function automatic logic [DIVN_W-1:0] abs_diff(input logic [DIVN_W-1:0] a,
                                                   input logic [DIVN_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Next-state, datapath and output decode for the ramp sequencer.
    always_comb begin
        state_d     = state_q;
        divn_d      = divn_q;
        target_d    = target_q;
        hold_d      = hold_q;
        lock_d      = lock_q;
        brake_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = clr_err ? 1'b0 : err_q;
        lock_meta_d = locked;
        lock_sync_d = lock_meta_q;
`ifdef PLL_RAMP_ABORT_EN
        aborted_d   = 1'b0;
`endif
        req_tgt  = (req_divn < DIVN_MIN_V) ? DIVN_MIN_V : req_divn;
        req_diff = abs_diff(req_tgt, divn_q);
        cur_diff = abs_diff(target_q, divn_q);
        // Never move further than the remaining distance, so no overshoot.
        step_amt = (cur_diff < STEP_V) ? cur_diff : STEP_V;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    target_d = req_tgt;
                    if (req_diff == '0) begin
                        done_d = 1'b1;
                    end else if (req_diff > BRAKE_V) begin
                        state_d = S_BRAKE;
                        brake_d = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_BRAKE: begin
                state_d = S_STEP;
            end
            S_STEP: begin
                divn_d  = (target_q > divn_q) ? (divn_q + step_amt) : (divn_q - step_amt);
                hold_d  = HOLD_LOAD;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_q == '0) begin
                    if (divn_q == target_q) begin
                        state_d = S_WAIT_LOCK;
                        lock_d  = '0;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                // A lock seen on the last allowed cycle still counts as success.
                if (lock_sync_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (lock_q == LOCK_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PLL_RAMP_ABORT_EN
        // Abort leaves divn where it is and returns quietly to IDLE.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            divn_d    = divn_q;
            hold_d    = hold_q;
            lock_d    = lock_q;
            brake_d   = 1'b0;
            done_d    = 1'b0;
            err_d     = clr_err ? 1'b0 : err_q;
            aborted_d = 1'b1;
        end
`endif
    end

    // All state and registered outputs; asynchronous active-low reset.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            divn_q      <= DIVN_INIT_V;
            target_q    <= DIVN_INIT_V;
            hold_q      <= '0;
            lock_q      <= '0;
            brake_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
`ifdef PLL_RAMP_ABORT_EN
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            divn_q      <= divn_d;
            target_q    <= target_d;
            hold_q      <= hold_d;
            lock_q      <= lock_d;
            brake_q     <= brake_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lock_meta_q <= lock_meta_d;
            lock_sync_q <= lock_sync_d;
`ifdef PLL_RAMP_ABORT_EN
            aborted_q   <= aborted_d;
`endif
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign divn        = divn_q;
    assign brake       = brake_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;
`ifdef PLL_RAMP_ABORT_EN
    assign aborted     = aborted_q;
`endif

endmodule

// File: tb/tb_pll_divn_ramp_ctrl.sv
// Bench for pll_divn_ramp_ctrl with short hold/timeout settings.
// For each request a reference model predicts the trace of divn values and the
// cycle of every divn change. It also predicts the brake cycle, the done cycle and
// the error flag. These are all counted from the accept edge.
module tb_pll_divn_ramp_ctrl;
  localparam int W     = 16;
  localparam int INIT  = 100;
  localparam int DMIN  = 4;
  localparam int STEPV = 1;
  localparam int H     = 4;
  localparam int BTH   = 64;
  localparam int T     = 16;

  logic          pclk;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_divn;
  logic          locked;
  logic          clr_err;
  logic [W-1:0]  divn;
  logic          brake;
  logic          busy;
  logic          done;
  logic          err_timeout;
  logic [2:0]    dbg_state;
`ifdef PLL_RAMP_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  int n_checks;
  int n_fail;
  int cur_divn;
  int exp_err;

  pll_divn_ramp_ctrl #(
    .DIVN_W(W), .DIVN_INIT(INIT), .DIVN_MIN(DMIN), .STEP(STEPV),
    .HOLD_CYCLES(H), .BRAKE_THRESH(BTH), .LOCK_TIMEOUT(T)
  ) dut (
    .pclk(pclk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_divn(req_divn),
    .locked(locked),
    .clr_err(clr_err),
`ifdef PLL_RAMP_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .divn(divn),
    .brake(brake),
    .busy(busy),
    .done(done),
    .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // One request, checked against the model.
  // lock_ok=0 expects a timeout; poke offers a stray request while busy;
  // clr_on_to raises clr_err on the same edge as the predicted timeout.
  task automatic run_req(input int req, input bit lock_ok, input bit poke, input bit clr_on_to);
    int tgt, delta, b, nsteps, v, n_done, n_end;
    int brake_cnt, brake_n, done_cnt, done_n, prev;
    logic [W-1:0] exp_q[$];
    int exp_n[$];
    logic [W-1:0] e_val;
    int e_n;

    tgt    = (req < DMIN) ? DMIN : req;
    delta  = (tgt > cur_divn) ? tgt - cur_divn : cur_divn - tgt;
    b      = (delta > BTH) ? 1 : 0;
    nsteps = (delta + STEPV - 1) / STEPV;
    v      = cur_divn;
    for (int i = 0; i < nsteps; i++) begin
      if (tgt > v) v = (tgt - v < STEPV) ? tgt : v + STEPV;
      else         v = (v - tgt < STEPV) ? tgt : v - STEPV;
      exp_q.push_back(W'(v));
      exp_n.push_back(1 + b + i * (H + 1));
    end
    if (delta == 0) n_done = 0;
    else            n_done = exp_n[exp_n.size()-1] + H + (lock_ok ? 1 : T);
    n_end = n_done + 2;

    @(negedge pclk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_divn  = W'(req);
    tick();
    req_valid = 1'b0;
    brake_cnt = 0; brake_n = -1; done_cnt = 0; done_n = -1;
    prev = cur_divn;
    for (int n = 0; n <= n_end; n++) begin
      if (n > 0) tick();
      if (int'(divn) != prev) begin
        if (exp_q.size() == 0) begin
          chk("extra_divn_change", divn, prev);
        end else begin
          e_val = exp_q.pop_front();
          e_n   = exp_n.pop_front();
          chk("divn_value", divn, e_val);
          chk("divn_change_cycle", n, e_n);
        end
        prev = int'(divn);
      end
      if (brake) begin brake_cnt++; brake_n = n; end
      if (done)  begin done_cnt++;  done_n = n; end
      if (delta != 0 && n == n_done - 1) chk("busy_before_done", busy, 1);
      if (n == n_done) chk("ready_at_done", req_ready, 1);
      if (poke && n == 2 && n_done > 6) begin
        req_valid = 1'b1;
        req_divn  = W'($urandom_range(0, 300));
      end
      if (n == 4) req_valid = 1'b0;
      if (clr_on_to && n == n_done - 1) clr_err = 1'b1;
      if (clr_on_to && n == n_done)     clr_err = 1'b0;
    end
    req_valid = 1'b0;
    chk("missing_divn_changes", exp_q.size(), 0);
    chk("brake_count", brake_cnt, b);
    if (b == 1) chk("brake_cycle", brake_n, 0);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_n, n_done);
    chk("divn_final", divn, tgt);
    if (!lock_ok) exp_err = 1;
    chk("err_timeout", err_timeout, exp_err);
    chk("idle_after", busy, 0);
    cur_divn = tgt;
  endtask

  initial begin
    int r;
    n_checks = 0; n_fail = 0;
    cur_divn = INIT; exp_err = 0;
    resetn = 1'b0; req_valid = 1'b0; req_divn = '0; locked = 1'b1; clr_err = 1'b0;
`ifdef PLL_RAMP_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    resetn = 1'b1;

    // Reset state held with no requests.
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("rst_divn", divn, INIT);
      chk("rst_flags", {req_ready, busy, brake, done, err_timeout}, 5'b10000);
    end

    // Directed cases.
    run_req(103, 1, 1, 0);   // small up-ramp, stray request mid-ramp
    run_req(20, 1, 0, 0);    // large down-jump, brake first
    run_req(2, 1, 0, 0);     // clamped to DIVN_MIN
    run_req(100, 1, 0, 0);   // delta 96, braked up-ramp
    run_req(100, 1, 0, 0);   // equal target: done next cycle

    // Random requests around the current value.
    for (int k = 0; k < 10; k++) begin
      r = cur_divn + int'($urandom_range(0, 180)) - 90;
      if (r < 0) r = int'($urandom_range(0, 3));
      run_req(r, 1, ($urandom_range(0, 1) == 1), 0);
    end

    // Lock never arrives: timeout, then clear, then clear colliding with a new timeout.
    locked = 1'b0;
    repeat (4) tick();
    run_req(cur_divn + 1, 0, 0, 0);
    @(negedge pclk); clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    #1;
    exp_err = 0;
    chk("clr_err_clears", err_timeout, 0);
    run_req(cur_divn + 2, 0, 0, 1);
    chk("set_beats_clear", err_timeout, 1);
    @(negedge pclk); clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    exp_err = 0;
    locked = 1'b1;
    repeat (4) tick();
    chk("err_cleared_again", err_timeout, 0);

`ifdef PLL_RAMP_ABORT_EN
    // Abort during HOLD at divn=102.
    run_req(100, 1, 0, 0);
    @(negedge pclk);
    req_valid = 1'b1; req_divn = W'(103);
    tick();
    req_valid = 1'b0;
    for (int n = 1; n <= 7; n++) tick();
    chk("abort_pre_divn", divn, 102);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_divn", divn, 102);
    chk("abort_pulse", aborted, 1);
    chk("abort_no_done", done, 0);
    chk("abort_idle", busy, 0);
    tick();
    chk("abort_pulse_end", aborted, 0);
    chk("abort_divn_hold", divn, 102);
    chk("abort_no_done2", done, 0);
    cur_divn = 102;
`endif

    // Asynchronous reset in the middle of a ramp.
    @(negedge pclk);
    req_valid = 1'b1; req_divn = W'(cur_divn > 60 ? cur_divn - 30 : cur_divn + 30);
    tick();
    req_valid = 1'b0;
    repeat (12) tick();
    chk("midramp_moved", (int'(divn) != cur_divn) ? 1 : 0, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_divn", divn, INIT);
    chk("async_rst_flags", {req_ready, busy, brake, done}, 4'b1000);
    @(negedge pclk); resetn = 1'b1;
    cur_divn = INIT;
    tick();
    chk("post_rst_divn", divn, INIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
